// File: rtl/psram_arbiter.sv
// psram_arbiter: shares one PsramController byte port between the slot/mapper FSM (A) and a background agent (B).
// Optional build macro PSRAM_ARB_ROUND_ROBIN_EN: simultaneous requests alternate instead of A always winning.
module psram_arbiter #(
  parameter int unsigned ADDR_W        = 22,
  parameter int unsigned START_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_din,
  output logic [7:0]        a_dout,
  output logic              a_ack,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_din,
  output logic [7:0]        b_dout,
  output logic              b_ack,

  output logic              psram_read,
  output logic              psram_write,
  output logic [ADDR_W-1:0] psram_addr,
  output logic [15:0]       psram_din,
  input  logic [15:0]       psram_dout,
  input  logic              psram_busy,

  output logic [1:0]        gnt
);

  localparam int unsigned CNT_W = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ISSUE      = 3'd1;
  localparam logic [2:0] S_WAIT_START = 3'd2;
  localparam logic [2:0] S_WAIT_DONE  = 3'd3;
  localparam logic [2:0] S_DONE       = 3'd4;
  localparam logic [2:0] S_RELEASE    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic [7:0]        a_dout_q, a_dout_d;
  logic [7:0]        b_dout_q, b_dout_d;

  logic              pick_b;
  logic              finish;
  logic [7:0]        rd_byte;

`ifdef PSRAM_ARB_ROUND_ROBIN_EN
  logic              last_b_q, last_b_d;

  // Tie goes to whoever was not served last; the flag resets to B so A wins the first tie.
  always_comb begin
    pick_b = b_req & (~a_req | ~last_b_q);
  end
`else
  always_comb begin
    pick_b = b_req & ~a_req;
  end
`endif

  always_comb begin
    rd_byte = addr_q[0] ? psram_dout[15:8] : psram_dout[7:0];
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    cnt_d    = cnt_q;
    a_ack_d  = 1'b0;
    b_ack_d  = 1'b0;
    a_dout_d = a_dout_q;
    b_dout_d = b_dout_q;
    finish   = 1'b0;
`ifdef PSRAM_ARB_ROUND_ROBIN_EN
    last_b_d = last_b_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!psram_busy && (a_req || b_req)) begin
          state_d = S_ISSUE;
          gnt_d   = pick_b ? 2'b10 : 2'b01;
          we_d    = pick_b ? b_we   : a_we;
          addr_d  = pick_b ? b_addr : a_addr;
          din_d   = pick_b ? b_din  : a_din;
          // Strobes are registered so they are high for exactly the ISSUE cycle.
          rd_d    = pick_b ? ~b_we : ~a_we;
          wr_d    = pick_b ?  b_we :  a_we;
`ifdef PSRAM_ARB_ROUND_ROBIN_EN
          last_b_d = pick_b;
`endif
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT_START;
        cnt_d   = '0;
      end

      S_WAIT_START: begin
        if (psram_busy) begin
          state_d = S_WAIT_DONE;
        end else if ((32'(cnt_q) + 32'd1) >= START_TIMEOUT) begin
          finish = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT_DONE: begin
        if (!psram_busy) begin
          finish = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_RELEASE;
        gnt_d   = '0;
      end

      S_RELEASE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase

    // Ack and read data are registered together so both appear in the DONE cycle.
    if (finish) begin
      state_d = S_DONE;
      a_ack_d = gnt_q[0];
      b_ack_d = gnt_q[1];
      if (!we_q) begin
        if (gnt_q[0]) begin
          a_dout_d = rd_byte;
        end
        if (gnt_q[1]) begin
          b_dout_d = rd_byte;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      a_dout_q <= '0;
      b_dout_q <= '0;
`ifdef PSRAM_ARB_ROUND_ROBIN_EN
      last_b_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
      a_dout_q <= a_dout_d;
      b_dout_q <= b_dout_d;
`ifdef PSRAM_ARB_ROUND_ROBIN_EN
      last_b_q <= last_b_d;
`endif
    end
  end

  assign psram_read  = rd_q;
  assign psram_write = wr_q;
  assign psram_addr  = addr_q;
  assign psram_din   = {din_q, din_q};
  assign a_dout      = a_dout_q;
  assign b_dout      = b_dout_q;
  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign gnt         = gnt_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Bench for psram_arbiter: behavioural PSRAM controller, expectation queue filled at stimulus time.
module tb_psram_arbiter;

  localparam int unsigned ADDR_W = 22;
  localparam int unsigned TO     = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              a_req, a_we, b_req, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [7:0]        a_din, b_din, a_dout, b_dout;
  logic              a_ack, b_ack;
  logic              psram_read, psram_write, psram_busy;
  logic [ADDR_W-1:0] psram_addr;
  logic [15:0]       psram_din, psram_dout;
  logic [1:0]        gnt;

  psram_arbiter #(.ADDR_W(ADDR_W), .START_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout), .b_ack(b_ack),
    .psram_read(psram_read), .psram_write(psram_write), .psram_addr(psram_addr),
    .psram_din(psram_din), .psram_dout(psram_dout), .psram_busy(psram_busy), .gnt(gnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: busy rises the cycle after a strobe and stays high blen cycles.
  logic [15:0] rd_word = 16'h0000;
  int          blen = 3;
  logic        force_busy = 1'b0;
  logic        no_busy = 1'b0;
  int          busy_cnt = 0;
  always @(posedge clk) begin
    if (reset) busy_cnt <= 0;
    else if ((psram_read || psram_write) && !no_busy) busy_cnt <= blen;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign psram_busy = force_busy | (busy_cnt != 0);
  assign psram_dout = rd_word;

  int                n_rd = 0, n_wr = 0, n_a_ack = 0, n_b_ack = 0, strobe_cyc = 0;
  logic [ADDR_W-1:0] strobe_addr = '0;
  logic [15:0]       strobe_din = '0;
  always @(negedge clk) begin
    if (psram_read || psram_write) begin
      strobe_cyc  <= cyc;
      strobe_addr <= psram_addr;
      strobe_din  <= psram_din;
    end
    if (psram_read)  n_rd    <= n_rd + 1;
    if (psram_write) n_wr    <= n_wr + 1;
    if (a_ack)       n_a_ack <= n_a_ack + 1;
    if (b_ack)       n_b_ack <= n_b_ack + 1;
  end

  typedef struct { bit port; logic [7:0] dout; } exp_t;
  typedef struct { bit port; logic [7:0] dout; bit both; int cyc; } obs_t;
  exp_t sb[$];
  obs_t obs[$];
  logic [7:0] exp_a = '0, exp_b = '0;
  int n_chk = 0, n_fail = 0;

  task automatic expect_acc(input bit port, input bit we, input logic [ADDR_W-1:0] addr);
    logic [7:0] v;
    exp_t e;
    if (!we) v = addr[0] ? rd_word[15:8] : rd_word[7:0];
    else     v = port ? exp_b : exp_a;
    if (port) exp_b = v; else exp_a = v;
    e.port = port;
    e.dout = v;
    sb.push_back(e);
  endtask

  task automatic collect(input int n, input int bound, input bit hold);
    int got, t;
    bit sa, sbk;
    obs_t o;
    got = 0; t = 0;
    while (got < n && t < bound) begin
      @(negedge clk); t++;
      if (a_ack || b_ack) begin
        o.port = b_ack; o.dout = b_ack ? b_dout : a_dout;
        o.both = a_ack && b_ack; o.cyc = cyc;
        obs.push_back(o);
        got++; sa = a_ack; sbk = b_ack;
        if (!hold) begin
          @(posedge clk); #1;
          if (sa) a_req = 1'b0;
          if (sbk) b_req = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_strobe(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (psram_read || psram_write) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_din = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_din = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({gnt, psram_read, psram_write, psram_addr, psram_din, a_dout, b_dout, a_ack, b_ack} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b rd=%b wr=%b addr=%h din=%h ad=%h bd=%h ack=%b%b, required all zero",
               gnt, psram_read, psram_write, psram_addr, psram_din, a_dout, b_dout, a_ack, b_ack);
    end
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_tie;
    exp_t e; obs_t o;
    blen = 2; rd_word = 16'hBEEF;
    a_we = 0; a_addr = 22'h000001; b_we = 0; b_addr = 22'h000000;
`ifdef PSRAM_ARB_ROUND_ROBIN_EN
    expect_acc(0, 0, a_addr); expect_acc(1, 0, b_addr);
    expect_acc(0, 0, a_addr); expect_acc(1, 0, b_addr);
`else
    for (int i = 0; i < 4; i++) expect_acc(0, 0, a_addr);
`endif
    a_req = 1; b_req = 1;
    collect(4, 200, 1'b1);
    @(posedge clk); #1 a_req = 0; b_req = 0;
    repeat (12) @(posedge clk);
    #1;
    n_chk++;
    if (obs.size() != 4 || n_a_ack + n_b_ack != 4) begin
      n_fail++;
      $display("FAIL tie_count: got %0d acks (total %0d), required 4", obs.size(), n_a_ack + n_b_ack);
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_chk++;
      if (o.port !== e.port || o.dout !== e.dout || o.both) begin
        n_fail++;
        $display("FAIL tie_order: got port %0d dout %h both %0d, required port %0d dout %h",
                 o.port, o.dout, o.both, e.port, e.dout);
      end
    end
    sb.delete(); obs.delete();
  endtask

  task automatic test_single_write;
    int r0, w0, a0, b0;
    exp_t e; obs_t o;
    blen = 3; r0 = n_rd; w0 = n_wr; a0 = n_a_ack; b0 = n_b_ack;
    a_we = 1; a_addr = 22'h012345; a_din = 8'h5A;
    expect_acc(0, 1, a_addr);
    a_req = 1;
    collect(1, 50, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    n_chk++;
    if (n_wr - w0 != 1 || n_rd - r0 != 0) begin
      n_fail++; $display("FAIL wr_strobe_count: got wr %0d rd %0d, required wr 1 rd 0", n_wr - w0, n_rd - r0);
    end
    n_chk++;
    if (strobe_addr !== 22'h012345) begin
      n_fail++; $display("FAIL wr_addr: got %h, required 012345", strobe_addr);
    end
    n_chk++;
    if (strobe_din !== 16'h5A5A) begin
      n_fail++; $display("FAIL wr_din: got %h, required 5a5a", strobe_din);
    end
    n_chk++;
    if (n_a_ack - a0 != 1 || n_b_ack - b0 != 0) begin
      n_fail++; $display("FAIL wr_ack_count: got a %0d b %0d, required a 1 b 0", n_a_ack - a0, n_b_ack - b0);
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_chk++;
      if (o.port !== e.port || o.dout !== e.dout || o.both) begin
        n_fail++; $display("FAIL wr_ack: got port %0d dout %h, required port %0d dout %h", o.port, o.dout, e.port, e.dout);
      end
    end
    n_chk++;
    if (sb.size() != 0 || obs.size() != 0) begin
      n_fail++; $display("FAIL wr_leftover: got sb %0d obs %0d, required 0 0", sb.size(), obs.size());
    end
    sb.delete(); obs.delete();
  endtask

  task automatic test_reads;
    exp_t e; obs_t o;
    logic [21:0] addrs [3] = '{22'h000001, 22'h000000, 22'h000003};
    bit          ports [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] words [3] = '{16'hBEEF, 16'hBEEF, 16'h1234};
    blen = 6;
    for (int i = 0; i < 3; i++) begin
      rd_word = words[i];
      if (ports[i]) begin b_we = 0; b_addr = addrs[i]; end
      else          begin a_we = 0; a_addr = addrs[i]; end
      expect_acc(ports[i], 0, addrs[i]);
      if (ports[i]) b_req = 1; else a_req = 1;
      collect(1, 60, 1'b0);
      n_chk++;
      if (obs.size() != 1) begin
        n_fail++; $display("FAIL read_ack_%0d: got %0d acks, required 1", i, obs.size());
      end else begin
        n_chk++;
        if (obs[0].cyc - strobe_cyc != blen + 2) begin
          n_fail++; $display("FAIL read_latency_%0d: got %0d, required %0d", i, obs[0].cyc - strobe_cyc, blen + 2);
        end
      end
      while (sb.size() > 0 && obs.size() > 0) begin
        e = sb.pop_front(); o = obs.pop_front(); n_chk++;
        if (o.port !== e.port || o.dout !== e.dout || o.both) begin
          n_fail++; $display("FAIL read_data_%0d: got port %0d dout %h, required port %0d dout %h",
                             i, o.port, o.dout, e.port, e.dout);
        end
      end
      sb.delete(); obs.delete();
      repeat (2) @(posedge clk);
      #1;
    end
    n_chk++;
    if (a_dout !== exp_a) begin
      n_fail++; $display("FAIL a_dout_hold: got %h, required %h", a_dout, exp_a);
    end
  endtask

  task automatic test_init_block;
    int r0, w0, fall;
    exp_t e; obs_t o;
    blen = 3; rd_word = 16'hBEEF;
    r0 = n_rd; w0 = n_wr;
    force_busy = 1; a_we = 0; a_addr = 22'h000004; a_req = 1;
    expect_acc(0, 0, a_addr);
    repeat (100) @(posedge clk);
    #1;
    n_chk++;
    if (n_rd != r0 || n_wr != w0) begin
      n_fail++; $display("FAIL init_no_strobe: got rd %0d wr %0d strobes, required 0", n_rd - r0, n_wr - w0);
    end
    @(posedge clk); #1 force_busy = 0; fall = cyc;
    collect(1, 50, 1'b0);
    n_chk++;
    if (strobe_cyc != fall + 1) begin
      n_fail++; $display("FAIL init_first_strobe: got cycle offset %0d, required 1", strobe_cyc - fall);
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_chk++;
      if (o.port !== e.port || o.dout !== e.dout) begin
        n_fail++; $display("FAIL init_data: got port %0d dout %h, required port %0d dout %h", o.port, o.dout, e.port, e.dout);
      end
    end
    n_chk++;
    if (sb.size() != 0 || obs.size() != 0) begin
      n_fail++; $display("FAIL init_leftover: got sb %0d obs %0d, required 0 0", sb.size(), obs.size());
    end
    sb.delete(); obs.delete();
  endtask

  task automatic test_timeout;
    exp_t e; obs_t o;
    no_busy = 1;
    a_we = 1; a_addr = 22'h3FFFFF; a_din = 8'hFF;
    expect_acc(0, 1, a_addr);
    a_req = 1;
    collect(1, 60, 1'b0);
    n_chk++;
    if (obs.size() != 1) begin
      n_fail++; $display("FAIL timeout_ack: got %0d acks, required 1", obs.size());
    end else begin
      n_chk++;
      if (obs[0].cyc - strobe_cyc != TO + 1) begin
        n_fail++; $display("FAIL timeout_latency: got %0d, required %0d", obs[0].cyc - strobe_cyc, TO + 1);
      end
    end
    n_chk++;
    if (gnt !== 2'b00) begin
      n_fail++; $display("FAIL timeout_release_gnt: got %b, required 00", gnt);
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_chk++;
      if (o.port !== e.port || o.dout !== e.dout) begin
        n_fail++; $display("FAIL timeout_data: got port %0d dout %h, required port %0d dout %h", o.port, o.dout, e.port, e.dout);
      end
    end
    sb.delete(); obs.delete();
    no_busy = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_req_change;
    bit seen;
    int w0;
    exp_t e; obs_t o;
    blen = 4; rd_word = 16'hBEEF; w0 = n_wr;
    a_we = 0; a_addr = 22'h000001;
    expect_acc(0, 0, a_addr);
    a_req = 1;
    wait_strobe(seen);
    n_chk++;
    if (!seen) begin
      n_fail++; $display("FAIL chg_strobe: got no strobe, required one within 40 cycles");
    end
    @(posedge clk); #1;
    a_addr = 22'h000000; a_we = 1; a_din = 8'h33; a_req = 0;
    collect(1, 40, 1'b0);
    n_chk++;
    if (psram_addr !== 22'h000001 || n_wr != w0) begin
      n_fail++; $display("FAIL chg_latched: got addr %h writes %0d, required 000001 0", psram_addr, n_wr - w0);
    end
    n_chk++;
    if (obs.size() != 1) begin
      n_fail++; $display("FAIL chg_ack: got %0d acks, required 1", obs.size());
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_chk++;
      if (o.port !== e.port || o.dout !== e.dout) begin
        n_fail++; $display("FAIL chg_data: got port %0d dout %h, required port %0d dout %h", o.port, o.dout, e.port, e.dout);
      end
    end
    sb.delete(); obs.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    exp_t e; obs_t o;
    blen = 3; rd_word = 16'h5AC3;
    a_we = 1; a_addr = 22'h000010; a_din = 8'h77;
    b_we = 0; b_addr = 22'h000011;
    expect_acc(0, 1, a_addr);
    expect_acc(1, 0, b_addr);
    a_req = 1;
    @(posedge clk); #1 b_req = 1;
    collect(2, 80, 1'b0);
    n_chk++;
    if (obs.size() != 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d acks, required 2", obs.size());
    end else begin
      n_chk++;
      if (obs[1].cyc - obs[0].cyc != blen + 5) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d, required %0d", obs[1].cyc - obs[0].cyc, blen + 5);
      end
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_chk++;
      if (o.port !== e.port || o.dout !== e.dout || o.both) begin
        n_fail++; $display("FAIL b2b_data: got port %0d dout %h, required port %0d dout %h", o.port, o.dout, e.port, e.dout);
      end
    end
    sb.delete(); obs.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    bit seen;
    int a0;
    exp_t e; obs_t o;
    blen = 20; rd_word = 16'hBEEF;
    a_we = 0; a_addr = 22'h000001; a_req = 1;
    wait_strobe(seen);
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (!seen || gnt !== 2'b01) begin
      n_fail++; $display("FAIL midrst_setup: got strobe %0d gnt %b, required 1 01", seen, gnt);
    end
    a0 = n_a_ack;
    reset = 1'b1;
    #1;
    n_chk++;
    if ({gnt, psram_read, psram_write, psram_addr, psram_din, a_dout, b_dout, a_ack, b_ack} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: gnt=%b addr=%h din=%h ad=%h bd=%h ack=%b%b, required all zero",
               gnt, psram_addr, psram_din, a_dout, b_dout, a_ack, b_ack);
    end
    a_req = 0; exp_a = '0; exp_b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_chk++;
    if (n_a_ack != a0 || n_b_ack + n_a_ack != a0 + n_b_ack) begin
      n_fail++; $display("FAIL midrst_no_ack: got %0d extra acks, required 0", n_a_ack - a0);
    end
    blen = 3; rd_word = 16'hCAFE;
    a_addr = 22'h000000;
    expect_acc(0, 0, a_addr);
    a_req = 1;
    collect(1, 50, 1'b0);
    n_chk++;
    if (obs.size() != 1) begin
      n_fail++; $display("FAIL midrst_fresh_ack: got %0d acks, required 1", obs.size());
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_chk++;
      if (o.port !== e.port || o.dout !== e.dout) begin
        n_fail++; $display("FAIL midrst_fresh_data: got port %0d dout %h, required port %0d dout %h",
                           o.port, o.dout, e.port, e.dout);
      end
    end
    sb.delete(); obs.delete();
  endtask

  initial begin
    test_reset;
    test_tie;
    test_single_write;
    test_reads;
    test_init_block;
    test_timeout;
    test_req_change;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

endmodule
